// File: rtl/calc_core.sv
// calc_core: keypad-driven signed calculator engine with iterative mul/div (CALC_CHAIN_EN enables result chaining)
module calc_core #(
  parameter int OP_W    = 8,
  parameter int MAG_MAX = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [2*OP_W-1:0] disp_val,
  output logic              result_valid,
  output logic              busy,
  output logic              err
);
  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(OP_W + 2);
  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_ADD, OP_SUB} op_t;
  state_t state, state_n;
  op_t op;
  logic [OP_W-1:0] opa, opb, mplier, quo, rem, rem_sub, ent_mag, ent_clamp;
  logic nega, negb, seena, seenb, div_ge, newneg;
  logic [OP_W+3:0] ent_sum;
  logic [OP_W:0] rem_sh;
  logic [RW-1:0] mcand, acc, res, res_n, sa, sb, mag_r;
  logic [CW-1:0] cnt, last;
  logic is_dig, is_op, is_neg, is_clr, is_eq;
  assign is_dig = key_valid && key_code < 4'd10;
  assign is_op  = key_valid && key_code >= 4'd10 && key_code <= 4'd13;
  assign is_neg = key_valid && key_code == 4'hB;
  assign is_clr = key_valid && key_code == 4'hE;
  assign is_eq  = key_valid && key_code == 4'hF;
  assign ent_mag   = state == S_B ? opb : state == S_A ? opa : '0;
  assign ent_sum   = ({4'd0, ent_mag} << 3) + ({4'd0, ent_mag} << 1) + {{OP_W{1'b0}}, key_code};
  assign ent_clamp = ent_sum > (OP_W+4)'(MAG_MAX) ? OP_W'(MAG_MAX) : ent_sum[OP_W-1:0];
  assign sa = nega ? -RW'(opa) : RW'(opa);
  assign sb = negb ? -RW'(opb) : RW'(opb);
  assign last    = (op == OP_ADD || op == OP_SUB) ? CW'(1) : CW'(OP_W + 1);
  assign rem_sh  = {rem, quo[OP_W-1]};
  assign div_ge  = rem_sh >= {1'b0, opb};
  assign rem_sub = rem_sh[OP_W-1:0] - opb;
  assign mag_r   = op == OP_MUL ? acc : RW'(quo);
  assign res_n   = op == OP_ADD ? sa + sb : op == OP_SUB ? sa - sb : (nega ^ negb) ? -mag_r : mag_r;
  assign busy    = state == S_EXEC;
  assign err     = state == S_ERR;
  assign disp_val = state == S_A ? sa : state == S_B ? (seenb ? sb : sa) :
                    state == S_EXEC ? sb : state == S_DONE ? res : '0;
`ifdef CALC_CHAIN_EN
  logic [RW-1:0] res_abs;
  logic chain;
  assign res_abs = res[RW-1] ? -res : res;
  assign chain   = is_op && res_abs <= RW'(MAG_MAX);
  assign newneg  = 1'b0;
`else
  assign newneg  = is_neg;
`endif
  // state register
  always_ff @(posedge clk)
    state <= !rst ? S_A : state_n;
  // next-state selection from key strobes and execution progress
  always_comb begin
    state_n = state;
    if (is_clr) state_n = S_A;
    else
      unique case (state)
        S_A:    state_n = (is_op && seena) ? S_B : S_A;
        S_B:    state_n = (is_eq && seenb) ? S_EXEC : S_B;
        S_EXEC: state_n = (cnt == '0 && op == OP_DIV && opb == '0) ? S_ERR : cnt == last ? S_DONE : S_EXEC;
`ifdef CALC_CHAIN_EN
        S_DONE: state_n = is_dig ? S_A : chain ? S_B : S_DONE;
`else
        S_DONE: state_n = (is_dig || newneg) ? S_A : S_DONE;
`endif
        S_ERR:  state_n = is_dig ? S_A : S_ERR;
        default: state_n = S_A;
      endcase
  end
  // operand entry, iterative execution and result posting
  always_ff @(posedge clk) begin
    if (!rst || is_clr) begin
      opa <= '0; opb <= '0; nega <= 1'b0; negb <= 1'b0; seena <= 1'b0; seenb <= 1'b0;
      op <= OP_ADD; res <= '0; result_valid <= 1'b0; cnt <= '0;
      acc <= '0; mcand <= '0; mplier <= '0; rem <= '0; quo <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        S_A:
          if (is_dig) begin opa <= ent_clamp; seena <= 1'b1; end
          else if (is_neg && !seena) nega <= ~nega;
          else if (is_op && seena) op <= op_t'(key_code[1:0]);
        S_B:
          if (is_dig) begin opb <= ent_clamp; seenb <= 1'b1; end
          else if (is_neg && !seenb) negb <= ~negb;
          else if (is_eq && seenb) begin
            cnt <= '0; acc <= '0; mcand <= RW'(opa); mplier <= opb; rem <= '0; quo <= opa;
          end
        S_EXEC: begin
          cnt <= cnt + CW'(1);
          if ((cnt == '0 && op == OP_DIV && opb == '0) || cnt == last) result_valid <= 1'b1;
          else if (cnt == last - CW'(1)) res <= res_n;
          else begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= div_ge ? rem_sub : rem_sh[OP_W-1:0];
            quo    <= {quo[OP_W-2:0], div_ge};
          end
        end
        S_DONE, S_ERR:
          if (is_dig || (state == S_DONE && newneg)) begin
            opa <= is_dig ? ent_clamp : '0; nega <= !is_dig; seena <= is_dig;
            opb <= '0; negb <= 1'b0; seenb <= 1'b0;
          end
`ifdef CALC_CHAIN_EN
          else if (state == S_DONE && chain) begin
            opa <= res_abs[OP_W-1:0]; nega <= res[RW-1]; seena <= 1'b1; op <= op_t'(key_code[1:0]);
            opb <= '0; negb <= 1'b0; seenb <= 1'b0;
          end
`endif
        default: ;
      endcase
    end
  end
endmodule
